// File: rtl/hk_fetch_seq_pkg.sv
// Shared definitions for the H/K fetch sequencer: FSM state encoding,
// selector values, counter widths and the SHA-256 constant tables.
package hk_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        READY   = 2'd1,
        FETCH_H = 2'd2,
        FETCH_K = 2'd3
    } hk_state_e;

    localparam logic        HSEL    = 1'b0;
    localparam logic        KSEL    = 1'b1;
    localparam int unsigned H_WORDS = 8;
    // Wide enough for the largest legal read latency (3).
    localparam int unsigned WAIT_W  = 2;

    localparam logic [31:0] H_CONST [H_WORDS] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_CONST [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/hk_fetch_seq_wait.sv
// Read-latency down-counter: loads READ_LAT, counts to zero and then
// reports expired until the next load. Shared by the H and K phases.
module hk_fetch_wait
    import hk_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Next count: reload on request, otherwise step down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = WAIT_W'(READ_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/hk_fetch_seq.sv
// H/K constant memory read initiator: runs the ROM copy after reset, then
// on each START reads the 8 H words (H_WE strobes) and streams NUM_K K words
// over K_VALID/K_READY. Optional selftest comparator under the
// HK_FETCH_SELFTEST_EN macro drives MISMATCH; otherwise MISMATCH is 0.
module hk_fetch_seq
    import hk_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned NUM_K    = 64
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    output logic        BUSY,
    output logic        INIT_DONE,
    output logic        DONE,
    output logic        COPY_ROM,
    input  logic        COPY_ROM_COMPLETE,
    output logic        HK_SELECTOR,
    output logic [2:0]  H_ADDR,
    output logic [5:0]  K_ADDR,
    input  logic [31:0] HK,
    output logic        H_WE,
    output logic        K_VALID,
    input  logic        K_READY,
    output logic [31:0] WORD,
    output logic [5:0]  IDX,
    output logic        MISMATCH
);

    localparam logic [2:0] H_LAST = 3'(H_WORDS - 1);
    localparam logic [5:0] K_LAST = 6'(NUM_K - 1);

    hk_state_e   state_q;
    logic        copy_rom_q;
    logic        init_done_q;
    logic        done_q;
    logic        hsel_q;
    logic [2:0]  h_addr_q;
    logic [5:0]  k_addr_q;
    logic        h_we_q;
    logic        k_valid_q;
    logic [31:0] word_q;
    logic [5:0]  idx_q;

    logic wait_exp;
    logic wait_load;
    logic start_go;
    logic h_cap;
    logic k_present;
    logic k_accept;
    logic k_last;

    // A START landing in the DONE cycle is dropped so each pass needs its own START.
    assign start_go  = (state_q == READY) && START && !done_q;
    assign h_cap     = (state_q == FETCH_H) && wait_exp;
    assign k_present = (state_q == FETCH_K) && wait_exp && !k_valid_q;
    assign k_accept  = k_valid_q && K_READY;
    assign k_last    = (k_addr_q == K_LAST);
    // Reload whenever a new address is launched toward the memory.
    assign wait_load = start_go || h_cap || (k_accept && !k_last);

    hk_fetch_wait #(.READ_LAT(READ_LAT)) u_wait (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .load_i    (wait_load),
        .expired_o (wait_exp)
    );

    // Sequencer FSM with all memory-side and consumer-side outputs registered.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= INIT;
            copy_rom_q  <= 1'b1;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            hsel_q      <= HSEL;
            h_addr_q    <= '0;
            k_addr_q    <= '0;
            h_we_q      <= 1'b0;
            k_valid_q   <= 1'b0;
            word_q      <= '0;
            idx_q       <= '0;
        end else begin
            h_we_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                INIT: begin
                    if (COPY_ROM_COMPLETE) begin
                        copy_rom_q  <= 1'b0;
                        init_done_q <= 1'b1;
                        state_q     <= READY;
                    end
                end
                READY: begin
                    if (start_go) begin
                        hsel_q   <= HSEL;
                        h_addr_q <= '0;
                        state_q  <= FETCH_H;
                    end
                end
                FETCH_H: begin
                    if (wait_exp) begin
                        word_q <= HK;
                        idx_q  <= {3'b000, h_addr_q};
                        h_we_q <= 1'b1;
                        if (h_addr_q == H_LAST) begin
                            hsel_q   <= KSEL;
                            k_addr_q <= '0;
                            state_q  <= FETCH_K;
                        end else begin
                            h_addr_q <= h_addr_q + 1'b1;
                        end
                    end
                end
                FETCH_K: begin
                    if (k_accept) begin
                        k_valid_q <= 1'b0;
                        if (k_last) begin
                            done_q  <= 1'b1;
                            state_q <= READY;
                        end else begin
                            k_addr_q <= k_addr_q + 1'b1;
                        end
                    end else if (k_present) begin
                        k_valid_q <= 1'b1;
                        word_q    <= HK;
                        idx_q     <= k_addr_q;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

`ifdef HK_FETCH_SELFTEST_EN
    logic mismatch_q;
    logic h_bad;
    logic k_bad;

    assign h_bad = (HK != H_CONST[h_addr_q]);
    assign k_bad = (HK != K_CONST[k_addr_q]);

    // Sticky flag: any captured word that differs from the reference tables.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mismatch_q <= 1'b0;
        end else if ((h_cap && h_bad) || (k_present && k_bad)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign MISMATCH = mismatch_q;
`else
    assign MISMATCH = 1'b0;
`endif

    assign BUSY        = (state_q == FETCH_H) || (state_q == FETCH_K);
    assign INIT_DONE   = init_done_q;
    assign DONE        = done_q;
    assign COPY_ROM    = copy_rom_q;
    assign HK_SELECTOR = hsel_q;
    assign H_ADDR      = h_addr_q;
    assign K_ADDR      = k_addr_q;
    assign H_WE        = h_we_q;
    assign K_VALID     = k_valid_q;
    assign WORD        = word_q;
    assign IDX         = idx_q;

endmodule

// File: tb/tb_hk_fetch_seq.sv
// Scoreboard bench for hk_fetch_seq with a READ_LAT=1 memory model.
module tb_hk_fetch_seq;
    import hk_pkg::*;

    localparam int unsigned LAT    = 1;
    localparam int unsigned NK     = 64;
    localparam logic [5:0]  K_LST  = 6'(NK - 1);
`ifdef HK_FETCH_SELFTEST_EN
    localparam logic        EXP_MM = 1'b1;
`else
    localparam logic        EXP_MM = 1'b0;
`endif

    localparam logic [31:0] EXP_H [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] EXP_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic        BUSY, INIT_DONE, DONE, COPY_ROM;
    logic        COPY_ROM_COMPLETE;
    logic        HK_SELECTOR;
    logic [2:0]  H_ADDR;
    logic [5:0]  K_ADDR;
    logic [31:0] HK;
    logic        H_WE, K_VALID, K_READY;
    logic [31:0] WORD;
    logic [5:0]  IDX;
    logic        MISMATCH;

    hk_fetch_seq #(.READ_LAT(LAT), .NUM_K(NK)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BUSY(BUSY),
        .INIT_DONE(INIT_DONE), .DONE(DONE), .COPY_ROM(COPY_ROM),
        .COPY_ROM_COMPLETE(COPY_ROM_COMPLETE), .HK_SELECTOR(HK_SELECTOR),
        .H_ADDR(H_ADDR), .K_ADDR(K_ADDR), .HK(HK), .H_WE(H_WE),
        .K_VALID(K_VALID), .K_READY(K_READY), .WORD(WORD), .IDX(IDX),
        .MISMATCH(MISMATCH)
    );

    always #5 CLK = ~CLK;

    // Memory model: one registered read stage; optional corruption of H word 3.
    logic [31:0] mem_q;
    logic        corrupt = 1'b0;
    always @(posedge CLK) mem_q <= HK_SELECTOR ? K_CONST[K_ADDR] : H_CONST[H_ADDR];
    assign HK = (corrupt && !HK_SELECTOR && H_ADDR == 3'd3) ? 32'h0 : mem_q;

    typedef struct packed {
        logic [1:0]  kind;   // 0 = H word, 1 = K word, 2 = DONE
        logic [5:0]  idx;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_h(input logic bad3);
        for (int i = 0; i < 8; i++)
            sb.push_back('{2'd0, 6'(i), (bad3 && i == 3) ? 32'h0 : EXP_H[i]});
    endtask

    task automatic push_k(input int n);
        for (int i = 0; i < n; i++) sb.push_back('{2'd1, 6'(i), EXP_K[i]});
    endtask

    task automatic push_pass(input logic bad3);
        push_h(bad3);
        push_k(NK);
        sb.push_back('{2'd2, 6'd0, 32'h0});
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_kaddr(input logic [5:0] a);
        for (int i = 0; i < 500 && !(HK_SELECTOR && K_ADDR == a); i++) tick();
        check("wait_kaddr", {26'd0, K_ADDR}, {26'd0, a});
    endtask

    task automatic wait_kvalid;
        for (int i = 0; i < 20 && !K_VALID; i++) tick();
        check("wait_kvalid", {31'd0, K_VALID}, 32'd1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 1000 && done_cnt < target; i++) tick();
        check("wait_done", done_cnt, target);
    endtask

    task automatic copy_complete;
        COPY_ROM_COMPLETE = 1'b1;
        tick();
        COPY_ROM_COMPLETE = 1'b0;
        check("copy_rom_off", {31'd0, COPY_ROM}, 32'd0);
        check("init_done", {31'd0, INIT_DONE}, 32'd1);
        check("busy_ready", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic pulse_start;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_start", {31'd0, BUSY}, 32'd1);
    endtask

    // Monitor: every DUT output event pops the next expected item.
    always @(negedge CLK) begin : monitor
        exp_t e;
        logic [1:0] kind;
        if (RESET_N === 1'b1 && (H_WE || DONE || (K_VALID && K_READY))) begin
            kind = H_WE ? 2'd0 : (DONE ? 2'd2 : 2'd1);
            if (sb.size() == 0) begin
                check("unexpected_event", {30'd0, kind}, 32'hffffffff);
            end else begin
                e = sb.pop_front();
                check("event_kind", {30'd0, kind}, {30'd0, e.kind});
                if (e.kind != 2'd2) begin
                    check("event_idx", {26'd0, IDX}, {26'd0, e.idx});
                    check("event_word", WORD, e.word);
                end
            end
            if (DONE) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        START = 1'b1;              // held through INIT, must be ignored
        COPY_ROM_COMPLETE = 1'b0;
        K_READY = 1'b1;
        tick();
        tick();
        check("rst_copy_rom", {31'd0, COPY_ROM}, 32'd1);
        check("rst_init_done", {31'd0, INIT_DONE}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_kvalid", {31'd0, K_VALID}, 32'd0);
        check("rst_hwe", {31'd0, H_WE}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_word", WORD, 32'h0);
        check("rst_idx", {26'd0, IDX}, 32'd0);
        check("rst_mismatch", {31'd0, MISMATCH}, 32'd0);
        RESET_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("init_copy_rom", {31'd0, COPY_ROM}, 32'd1);
            check("init_busy", {31'd0, BUSY}, 32'd0);
        end
        START = 1'b0;
        copy_complete();
        tick();
        check("idle_busy", {31'd0, BUSY}, 32'd0);

        // Pass 1: full stream; START held from K 30 through the DONE cycle.
        push_pass(1'b0);
        pulse_start();
        wait_kaddr(6'd30);
        START = 1'b1;
        for (int i = 0; i < 1000 && !DONE; i++) tick();
        check("done_seen", {31'd0, DONE}, 32'd1);
        tick();
        START = 1'b0;
        check("done_pulse", {31'd0, DONE}, 32'd0);
        check("done_busy", {31'd0, BUSY}, 32'd0);
        check("hold_h_addr", {29'd0, H_ADDR}, 32'd7);
        check("hold_k_addr", {26'd0, K_ADDR}, {26'd0, K_LST});
        tick();
        tick();
        check("no_restart", {31'd0, BUSY}, 32'd0);
        check("pass1_sb_empty", sb.size(), 0);
        check("pass1_mismatch", {31'd0, MISMATCH}, 32'd0);

        // Pass 2: backpressure at K word 5.
        push_pass(1'b0);
        pulse_start();
        wait_kaddr(6'd5);
        K_READY = 1'b0;
        wait_kvalid();
        for (int i = 0; i < 10; i++) begin
            check("bp_kvalid", {31'd0, K_VALID}, 32'd1);
            check("bp_word", WORD, 32'h59f111f1);
            check("bp_idx", {26'd0, IDX}, 32'd5);
            check("bp_kaddr", {26'd0, K_ADDR}, 32'd5);
            tick();
        end
        K_READY = 1'b1;
        wait_done(2);
        tick();

        // Pass 3: reset while K word 20 is presented.
        push_h(1'b0);
        push_k(20);
        pulse_start();
        wait_kaddr(6'd20);
        K_READY = 1'b0;
        wait_kvalid();
        check("k20_idx", {26'd0, IDX}, 32'd20);
        RESET_N = 1'b0;
        tick();
        check("mid_rst_kvalid", {31'd0, K_VALID}, 32'd0);
        check("mid_rst_copy_rom", {31'd0, COPY_ROM}, 32'd1);
        check("mid_rst_init_done", {31'd0, INIT_DONE}, 32'd0);
        check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        check("pass3_sb_empty", sb.size(), 0);
        RESET_N = 1'b1;
        K_READY = 1'b1;
        tick();
        tick();
        check("reinit_copy_rom", {31'd0, COPY_ROM}, 32'd1);
        copy_complete();

        // Pass 4: restart from H 0 with H word 3 corrupted in memory.
        corrupt = 1'b1;
        push_pass(1'b1);
        pulse_start();
        wait_done(3);
        corrupt = 1'b0;
        tick();
        check("mismatch_set", {31'd0, MISMATCH}, {31'd0, EXP_MM});
        repeat (5) tick();
        check("mismatch_sticky", {31'd0, MISMATCH}, {31'd0, EXP_MM});
        check("pass4_sb_empty", sb.size(), 0);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check("mismatch_cleared", {31'd0, MISMATCH}, 32'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
